// File: rtl/rd_stream_sequencer.sv
// rd_stream_sequencer: read-side front end for the convolution AFU.
// Walks up to NUM_STREAMS memory streams in round-robin chunks, tags each
// cacheline read with its stream id, routes responses back to per-stream
// sinks one cycle later and reports done once everything has returned.
module rd_stream_sequencer #(
    parameter int ADDR_LMT        = 58,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int NUM_STREAMS     = 3,
    parameter int TAG_W           = 3,
    parameter int CHUNK_MAX       = 8192,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_STREAMS*ADDR_LMT-1:0] cfg_base,
    input  logic [NUM_STREAMS*32-1:0]       cfg_len,
    input  logic [NUM_STREAMS-1:0]          sink_almostfull,
    output logic [ADDR_LMT-1:0]             rd_req_addr,
    output logic [MDATA-1:0]                rd_req_mdata,
    output logic                            rd_req_en,
    input  logic                            rd_req_almostfull,
    input  logic                            rd_rsp_valid,
    input  logic [MDATA-1:0]                rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0]          rd_rsp_data,
    output logic [NUM_STREAMS-1:0]          sink_valid,
    output logic [CACHE_WIDTH-1:0]          sink_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err_bad_tag,
    output logic                            err_underflow
);

    localparam int CUR_W   = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int CHUNK_W = $clog2(CHUNK_MAX + 1);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Per-stream configuration and progress
    logic [ADDR_LMT-1:0] base_q [NUM_STREAMS];
    logic [ADDR_LMT-1:0] base_d [NUM_STREAMS];
    logic [31:0]         len_q  [NUM_STREAMS];
    logic [31:0]         len_d  [NUM_STREAMS];
    logic [31:0]         off_q  [NUM_STREAMS];
    logic [31:0]         off_d  [NUM_STREAMS];

    logic [CHUNK_W-1:0]     chunk_q, chunk_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [OUT_W-1:0]       outst_q, outst_d;

    // Registered request and sink outputs
    logic                   rd_req_en_q, rd_req_en_d;
    logic [ADDR_LMT-1:0]    rd_req_addr_q, rd_req_addr_d;
    logic [MDATA-1:0]       rd_req_mdata_q, rd_req_mdata_d;
    logic [NUM_STREAMS-1:0] sink_valid_q, sink_valid_d;
    logic [CACHE_WIDTH-1:0] sink_data_q, sink_data_d;
    logic                   err_bad_tag_q, err_bad_tag_d;
    logic                   err_underflow_q, err_underflow_d;

    // Scheduling decode
    logic [NUM_STREAMS-1:0] rem_nz;
    logic [CUR_W-1:0]       first_nz;
    logic [CUR_W-1:0]       nxt_cur;
    logic                   nxt_found;
    logic                   switch_cyc;
    logic                   issue;
    logic                   start_ok;
    logic                   all_len_zero;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   tag_ok;

    // Only the low TAG_W bits of the response tag carry routing information.
    logic unused_mdata_hi;
    assign unused_mdata_hi = ^rd_rsp_mdata[MDATA-1:TAG_W];

    // Decode which streams still have work, pick the next stream and decide on issue.
    always_comb begin
        int               idx;
        logic [CUR_W-1:0] ci;
        idx       = 0;
        ci        = '0;
        rem_nz    = '0;
        first_nz  = '0;
        nxt_found = 1'b0;
        nxt_cur   = cur_q;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            rem_nz[s] = (off_q[s] != len_q[s]);
        end
        // Lowest non-empty stream in the incoming configuration
        for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
            if (cfg_len[s*32 +: 32] != 32'd0) begin
                first_nz = CUR_W'(s);
            end
        end
        // Cyclic search starting just after cur; cur itself is checked last
        for (int k = 1; k <= NUM_STREAMS; k++) begin
            idx = int'(cur_q) + k;
            if (idx >= NUM_STREAMS) begin
                idx = idx - NUM_STREAMS;
            end
            ci = CUR_W'(idx);
            if (!nxt_found && rem_nz[ci]) begin
                nxt_found = 1'b1;
                nxt_cur   = ci;
            end
        end
        all_len_zero = (cfg_len == '0);
        start_ok     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        switch_cyc   = (chunk_q == CHUNK_W'(CHUNK_MAX)) || !rem_nz[cur_q];
        issue        = (state_q == S_RUN) && !switch_cyc && !rd_req_almostfull &&
                       (outst_q < OUT_W'(MAX_OUTSTANDING)) && !sink_almostfull[cur_q] &&
                       rem_nz[cur_q];
        rsp_tag      = rd_rsp_mdata[TAG_W-1:0];
        tag_ok       = (int'(rsp_tag) < NUM_STREAMS);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start launches a run, running out of work drains, drained means done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = all_len_zero ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (switch_cyc && !nxt_found) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status levels decoded from the state.
    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Datapath next values: configuration latch, request generation, credit count, routing.
    always_comb begin
        base_d          = base_q;
        len_d           = len_q;
        off_d           = off_q;
        chunk_d         = chunk_q;
        cur_d           = cur_q;
        outst_d         = outst_q;
        rd_req_en_d     = issue;
        rd_req_addr_d   = rd_req_addr_q;
        rd_req_mdata_d  = rd_req_mdata_q;
        sink_valid_d    = '0;
        sink_data_d     = sink_data_q;
        err_bad_tag_d   = err_bad_tag_q;
        err_underflow_d = err_underflow_q;

        if (start_ok) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                base_d[s] = cfg_base[s*ADDR_LMT +: ADDR_LMT];
                len_d[s]  = cfg_len[s*32 +: 32];
                off_d[s]  = 32'd0;
            end
            chunk_d         = '0;
            cur_d           = first_nz;
            err_bad_tag_d   = 1'b0;
            err_underflow_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (switch_cyc) begin
                // One bubble cycle to move on; cur may be reselected if it is the last one left
                chunk_d = '0;
                if (nxt_found) begin
                    cur_d = nxt_cur;
                end
            end else if (issue) begin
                rd_req_addr_d  = base_q[cur_q] + ADDR_LMT'(off_q[cur_q]);
                rd_req_mdata_d = MDATA'(cur_q);
                off_d[cur_q]   = off_q[cur_q] + 32'd1;
                chunk_d        = chunk_q + 1'b1;
            end
        end

        // Issue and response in the same cycle cancel; never wrap below zero
        if (issue && !rd_rsp_valid) begin
            outst_d = outst_q + 1'b1;
        end else if (!issue && rd_rsp_valid && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end

        if (rd_rsp_valid && (outst_q == '0)) begin
            err_underflow_d = 1'b1;
        end
        if (rd_rsp_valid && !tag_ok) begin
            err_bad_tag_d = 1'b1;
        end
        if (rd_rsp_valid && tag_ok) begin
            sink_data_d = rd_rsp_data;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                sink_valid_d[s] = (rsp_tag == TAG_W'(s));
            end
        end
    end

    // Control and output registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                len_q[s] <= 32'd0;
                off_q[s] <= 32'd0;
            end
            chunk_q         <= '0;
            cur_q           <= '0;
            outst_q         <= '0;
            rd_req_en_q     <= 1'b0;
            rd_req_addr_q   <= '0;
            rd_req_mdata_q  <= '0;
            sink_valid_q    <= '0;
            sink_data_q     <= '0;
            err_bad_tag_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            len_q           <= len_d;
            off_q           <= off_d;
            chunk_q         <= chunk_d;
            cur_q           <= cur_d;
            outst_q         <= outst_d;
            rd_req_en_q     <= rd_req_en_d;
            rd_req_addr_q   <= rd_req_addr_d;
            rd_req_mdata_q  <= rd_req_mdata_d;
            sink_valid_q    <= sink_valid_d;
            sink_data_q     <= sink_data_d;
            err_bad_tag_q   <= err_bad_tag_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Base addresses are only meaningful after a start, so they carry no reset.
    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

    assign rd_req_en     = rd_req_en_q;
    assign rd_req_addr   = rd_req_addr_q;
    assign rd_req_mdata  = rd_req_mdata_q;
    assign sink_valid    = sink_valid_q;
    assign sink_data     = sink_data_q;
    assign err_bad_tag   = err_bad_tag_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_rd_stream_sequencer.sv
// Directed bench for rd_stream_sequencer: 3 streams, chunks of 4, cap of 4 in flight.
module tb_rd_stream_sequencer;

    localparam int AW = 58;
    localparam int MW = 14;
    localparam int CW = 64;
    localparam int NS = 3;
    localparam logic [63:0] DPAT = 64'hA5A5_0000_0000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NS*AW-1:0]  cfg_base = '0;
    logic [NS*32-1:0]  cfg_len = '0;
    logic [NS-1:0]     sink_almostfull = '0;
    logic [AW-1:0]     rd_req_addr;
    logic [MW-1:0]     rd_req_mdata;
    logic              rd_req_en;
    logic              rd_req_almostfull = 1'b0;
    logic              rd_rsp_valid = 1'b0;
    logic [MW-1:0]     rd_rsp_mdata = '0;
    logic [CW-1:0]     rd_rsp_data = '0;
    logic [NS-1:0]     sink_valid;
    logic [CW-1:0]     sink_data;
    logic              busy, done, err_bad_tag, err_underflow;

    rd_stream_sequencer #(
        .ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .NUM_STREAMS(NS),
        .TAG_W(3), .CHUNK_MAX(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .sink_almostfull(sink_almostfull), .rd_req_addr(rd_req_addr),
        .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data), .sink_valid(sink_valid),
        .sink_data(sink_data), .busy(busy), .done(done), .err_bad_tag(err_bad_tag),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [MW-1:0] md;
        logic [63:0] data;
    } rsp_t;

    rsp_t        pq[$];
    int          cyc = 0;
    int          n_req = 0;
    int          n_snk = 0;
    int          errors = 0;
    int          checks = 0;
    bit          hold = 1'b0;
    logic [63:0] req_addr [64];
    logic [MW-1:0] req_tag [64];
    int          req_cyc [64];
    logic [NS-1:0] snk_mask [64];
    logic [63:0] snk_data [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, record DUT activity, and drive this cycle's response.
    task automatic step();
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_req_en && n_req < 64) begin
            req_addr[n_req] = 64'(rd_req_addr);
            req_tag[n_req]  = rd_req_mdata;
            req_cyc[n_req]  = cyc;
            n_req++;
            r.due  = cyc + 3;
            r.md   = rd_req_mdata;
            r.data = DPAT | 64'(rd_req_addr);
            pq.push_back(r);
        end
        if (sink_valid != '0 && n_snk < 64) begin
            snk_mask[n_snk] = sink_valid;
            snk_data[n_snk] = sink_data;
            n_snk++;
        end
        if (!hold && pq.size() > 0 && pq[0].due <= cyc) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_mdata = pq[0].md;
            rd_rsp_data  = pq[0].data;
            void'(pq.pop_front());
        end else begin
            rd_rsp_valid = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [NS*AW-1:0] b, input logic [NS*32-1:0] l);
        cfg_base = b;
        cfg_len  = l;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) step();
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_reqs(input int n0, input int k, input string tag);
        for (int i = 0; i < 100 && (n_req - n0) < k; i++) step();
        chk(tag, 64'(n_req - n0), 64'(k));
    endtask

    initial begin
        int          n0, n1, s0;
        logic [63:0] e_addr [8];
        logic [2:0]  e_tag  [8];
        int          e_gap  [8];
        logic [2:0]  e_mask [8];
        e_addr = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h200, 64'h201, 64'h104, 64'h105};
        e_tag  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        e_gap  = '{0, 1, 2, 3, 5, 6, 8, 9};
        e_mask = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001};

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        chk("rst_req_en", 64'(rd_req_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sink_valid", 64'(sink_valid), 64'd0);
        chk("rst_errs", {62'd0, err_bad_tag, err_underflow}, 64'd0);

        // 1: round robin over {6,2,0}, responses 3 cycles after each request
        n0 = n_req;
        s0 = n_snk;
        pulse_start({58'h300, 58'h200, 58'h100}, {32'd0, 32'd2, 32'd6});
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done");
        chk("t1_nreq", 64'(n_req - n0), 64'd8);
        chk("t1_nsink", 64'(n_snk - s0), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_addr%0d", i), req_addr[n0+i], e_addr[i]);
            chk($sformatf("t1_tag%0d", i), 64'(req_tag[n0+i]), 64'(e_tag[i]));
            chk($sformatf("t1_gap%0d", i), 64'(req_cyc[n0+i] - req_cyc[n0]), 64'(e_gap[i]));
            chk($sformatf("t1_smask%0d", i), 64'(snk_mask[s0+i]), 64'(e_mask[i]));
            chk($sformatf("t1_sdata%0d", i), snk_data[s0+i], DPAT | e_addr[i]);
        end
        chk("t1_busy_end", 64'(busy), 64'd0);

        // 2: all lengths zero -> done two cycles after start, no requests
        n0 = n_req;
        pulse_start({58'h300, 58'h200, 58'h100}, '0);
        chk("t2_done_c1", 64'(done), 64'd0);
        chk("t2_busy_c1", 64'(busy), 64'd1);
        step();
        chk("t2_done_c2", 64'(done), 64'd1);
        chk("t2_nreq", 64'(n_req - n0), 64'd0);

        // 3: cap of 4 outstanding with responses withheld
        hold = 1'b1;
        n0 = n_req;
        pulse_start({58'h0, 58'h0, 58'h400}, {32'd0, 32'd0, 32'd10});
        repeat (12) step();
        chk("t3_cap4", 64'(n_req - n0), 64'd4);
        hold = 1'b0;
        step();
        hold = 1'b1;
        repeat (10) step();
        chk("t3_one_more", 64'(n_req - n0), 64'd5);
        hold = 1'b0;
        wait_done("t3_done");
        chk("t3_nreq", 64'(n_req - n0), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_addr%0d", i), req_addr[n0+i], 64'h400 + 64'(i));
        end

        // 4: request-channel and sink backpressure mid-stream
        n0 = n_req;
        pulse_start({58'h0, 58'h0, 58'h500}, {32'd0, 32'd0, 32'd12});
        wait_reqs(n0, 2, "t4_first2");
        rd_req_almostfull = 1'b1;
        n1 = n_req;
        repeat (5) step();
        chk("t4_af_stall", 64'(n_req - n1), 64'd0);
        rd_req_almostfull = 1'b0;
        wait_reqs(n0, 7, "t4_next5");
        sink_almostfull = 3'b001;
        n1 = n_req;
        repeat (3) step();
        chk("t4_sink_stall", 64'(n_req - n1), 64'd0);
        sink_almostfull = 3'b000;
        wait_done("t4_done");
        chk("t4_nreq", 64'(n_req - n0), 64'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t4_addr%0d", i), req_addr[n0+i], 64'h500 + 64'(i));
        end

        // 5: bad tag while one read is in flight, then a response with nothing outstanding
        hold = 1'b1;
        n0 = n_req;
        pulse_start({58'h0, 58'h0, 58'h800}, {32'd0, 32'd0, 32'd1});
        wait_reqs(n0, 1, "t5_req");
        s0 = n_snk;
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = 14'd5;
        rd_rsp_data  = 64'hBAD0;
        step();
        step();
        chk("t5_badtag_nosink", 64'(n_snk - s0), 64'd0);
        chk("t5_err_bad_tag", 64'(err_bad_tag), 64'd1);
        chk("t5_no_underflow_yet", 64'(err_underflow), 64'd0);
        pq.delete();
        wait_done("t5_done");
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = 14'd6;
        rd_rsp_data  = 64'hBAD1;
        step();
        repeat (4) step();
        chk("t5_nosink2", 64'(n_snk - s0), 64'd0);
        chk("t5_err_underflow", 64'(err_underflow), 64'd1);
        chk("t5_bad_tag_sticky", 64'(err_bad_tag), 64'd1);

        // 6: reset with 3 reads in flight, stale responses, then a fresh run
        n0 = n_req;
        pulse_start({58'h0, 58'h0, 58'h600}, {32'd0, 32'd0, 32'd8});
        chk("t6_start_clr_bad", 64'(err_bad_tag), 64'd0);
        chk("t6_start_clr_und", 64'(err_underflow), 64'd0);
        wait_reqs(n0, 3, "t6_three");
        reset = 1'b1;
        step();
        step();
        chk("t6_rst_req_en", 64'(rd_req_en), 64'd0);
        chk("t6_rst_addr", 64'(rd_req_addr), 64'd0);
        chk("t6_rst_mdata", 64'(rd_req_mdata), 64'd0);
        chk("t6_rst_sink", {61'd0, sink_valid}, 64'd0);
        chk("t6_rst_sdata", sink_data, 64'd0);
        chk("t6_rst_status", {60'd0, busy, done, err_bad_tag, err_underflow}, 64'd0);
        reset = 1'b0;
        hold  = 1'b0;
        repeat (6) step();
        chk("t6_stale_underflow", 64'(err_underflow), 64'd1);
        chk("t6_stale_drained", 64'(pq.size()), 64'd0);
        n0 = n_req;
        pulse_start({58'h0, 58'h0, 58'h700}, {32'd0, 32'd0, 32'd2});
        chk("t6_new_clr_und", 64'(err_underflow), 64'd0);
        wait_done("t6_done");
        chk("t6_nreq", 64'(n_req - n0), 64'd2);
        chk("t6_addr0", req_addr[n0], 64'h700);
        chk("t6_addr1", req_addr[n0+1], 64'h701);
        chk("t6_no_err", {62'd0, err_bad_tag, err_underflow}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
